// File: rtl/obi_resp_pkg.sv
// rtl/obi_resp_pkg.sv - shared types, widths and parameter legality helper for the OBI random responder
package obi_resp_pkg;

   localparam int CNT_W        = 3;
   localparam int PTR_W        = 2;
   localparam int PND_MIN      = 1;
   localparam int PND_MAX      = 4;
   localparam int TXN_ADDR_MAX = 64;
   localparam int TXN_DATA_MAX = 64;
   localparam int TXN_BE_MAX   = TXN_DATA_MAX / 8;

   // Stored at maximum width; the top zero-extends on push and slices on read.
   typedef struct packed {
      logic [TXN_ADDR_MAX-1:0] addr;
      logic                    we;
      logic [TXN_BE_MAX-1:0]   be;
   } obi_txn_t;

   function automatic bit params_legal(int max_pnd, int max_stall, int max_lat,
                                       int addr_w, int data_w);
      return (max_pnd >= PND_MIN) && (max_pnd <= PND_MAX) &&
             (max_stall >= 0) && (max_lat >= 0) &&
             (addr_w >= 1) && (addr_w <= TXN_ADDR_MAX) &&
             (data_w >= 8) && (data_w <= TXN_DATA_MAX) && (data_w % 8 == 0);
   endfunction

endpackage

// File: rtl/obi_rand_responder_if.sv
// rtl/obi_rand_responder_if.sv - OBI request/response bus between core port and responder
interface obi_rand_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_i;
   logic [ADDR_W-1:0]     addr_i;
   logic                  we_i;
   logic [DATA_W/8-1:0]   be_i;
   logic [DATA_W-1:0]     wdata_i;
   logic                  gnt_o;
   logic                  rvalid_o;
   logic [DATA_W-1:0]     rdata_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/obi_resp_fifo.sv
// rtl/obi_resp_fifo.sv - circular FIFO of granted transactions awaiting their response
module obi_resp_fifo
   import obi_resp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  obi_txn_t         push_txn,
   input  logic             pop,
   output logic [CNT_W-1:0] cnt,
   output obi_txn_t         head
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   obi_txn_t         mem [2**PTR_W];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload storage needs no reset: an entry is only visible once cnt covers it.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_txn;
   end

   assign head = (cnt == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/obi_rand_responder.sv
// rtl/obi_rand_responder.sv - protocol-legal OBI responder driven by free solver inputs with bounded liveness
module obi_rand_responder
   import obi_resp_pkg::*;
#(
   parameter int MAX_PND   = 2,
   parameter int MAX_STALL = 4,
   parameter int MAX_LAT   = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   obi_rand_responder_if.slave   bus,
   input  logic                  gnt_rand_i,
   input  logic                  rvalid_rand_i,
   input  logic [DATA_W-1:0]     rdata_rand_i,
   output logic [CNT_W-1:0]      pnd_cnt_o,
   output logic [ADDR_W-1:0]     rsp_addr_o,
   output logic                  rsp_we_o
);

   localparam int STALL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
   localparam int LAT_W   = (MAX_LAT < 1)   ? 1 : $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0]   PND_LIM   = CNT_W'(MAX_PND);
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL);
   localparam logic [LAT_W-1:0]   LAT_LIM   = LAT_W'(MAX_LAT);

   generate
      if (!params_legal(MAX_PND, MAX_STALL, MAX_LAT, ADDR_W, DATA_W)) begin : g_bad_params
         $error("obi_rand_responder: illegal parameter combination");
      end
   endgenerate

   logic [CNT_W-1:0]   cnt;
   logic [STALL_W-1:0] stall_cnt;
   logic [LAT_W-1:0]   lat_cnt;
   logic               full;
   logic               empty;
   logic               gnt;
   logic               rvalid;
   logic               push;
   obi_txn_t           push_txn;
   obi_txn_t           head;
   logic               unused_bits;

   assign full  = (cnt == PND_LIM);
   assign empty = (cnt == '0);

   // Reset gating keeps grants quiet during the cycle reset is being sampled.
   assign gnt    = !reset && bus.req_i && !full && (gnt_rand_i || (stall_cnt == STALL_LIM));
   assign rvalid = !empty && (rvalid_rand_i || (lat_cnt == LAT_LIM));
   assign push   = bus.req_i && gnt;

   always_comb begin
      push_txn      = '0;
      push_txn.addr = TXN_ADDR_MAX'(bus.addr_i);
      push_txn.we   = bus.we_i;
      push_txn.be   = TXN_BE_MAX'(bus.be_i);
   end

   obi_resp_fifo #(
      .DEPTH (MAX_PND)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .push_txn (push_txn),
      .pop      (rvalid),
      .cnt      (cnt),
      .head     (head)
   );

   // Stall counter freezes while full so a backed-up port keeps its credit.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (!bus.req_i || gnt) begin
         stall_cnt <= '0;
      end else if (full) begin
         stall_cnt <= stall_cnt;
      end else if (stall_cnt != STALL_LIM) begin
         stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_cnt <= '0;
      end else if (empty || rvalid) begin
         lat_cnt <= '0;
      end else if (lat_cnt != LAT_LIM) begin
         lat_cnt <= lat_cnt + LAT_W'(1);
      end
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid;
   assign bus.rdata_o  = (!empty && !head.we) ? rdata_rand_i : '0;
   assign pnd_cnt_o    = cnt;
   assign rsp_addr_o   = head.addr[ADDR_W-1:0];
   assign rsp_we_o     = head.we;

   assign unused_bits = ^{head, bus.wdata_i};

endmodule

// File: tb/tb_obi_rand_responder.sv
// tb/tb_obi_rand_responder.sv - directed self-checking bench for obi_rand_responder
module tb_obi_rand_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        gnt_rand;
   logic        rvalid_rand;
   logic [31:0] rdata_rand;
   logic [2:0]  pnd_cnt;
   logic [31:0] rsp_addr;
   logic        rsp_we;
   int          errors = 0;
   int          checks = 0;

   always #5 clock = ~clock;

   obi_rand_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   obi_rand_responder #(
      .MAX_PND   (2),
      .MAX_STALL (4),
      .MAX_LAT   (4),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus.slave),
      .gnt_rand_i    (gnt_rand),
      .rvalid_rand_i (rvalid_rand),
      .rdata_rand_i  (rdata_rand),
      .pnd_cnt_o     (pnd_cnt),
      .rsp_addr_o    (rsp_addr),
      .rsp_we_o      (rsp_we)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.req_i = 1'b1; gnt_rand = 1'b1; rvalid_rand = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(); #3;
         checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt[%0d]: got %b want 0", i, bus.gnt_o); end
      end
      cyc(); reset = 1'b0; bus.req_i = 1'b0; gnt_rand = 1'b0; rvalid_rand = 1'b1; #3;
      checks++; if (pnd_cnt !== 3'd0) begin errors++; $display("FAIL reset_pnd: got %0d want 0", pnd_cnt); end
      checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid_empty: got %b want 0", bus.rvalid_o); end
   endtask

   task automatic test_single_read();
      cyc(); bus.req_i = 1'b1; bus.addr_i = 32'h1A00_0080; bus.we_i = 1'b0; bus.be_i = 4'hF;
      gnt_rand = 1'b1; rvalid_rand = 1'b1; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL sr_gnt: got %b want 1", bus.gnt_o); end
      checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL sr_no_rvalid_in_gnt_cycle: got %b want 0", bus.rvalid_o); end
      cyc(); bus.req_i = 1'b0; gnt_rand = 1'b0; rdata_rand = 32'hDEAD_BEEF; rvalid_rand = 1'b1; #3;
      checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL sr_rvalid: got %b want 1", bus.rvalid_o); end
      checks++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rdata: got %h want deadbeef", bus.rdata_o); end
      checks++; if (rsp_addr !== 32'h1A00_0080) begin errors++; $display("FAIL sr_rsp_addr: got %h want 1a000080", rsp_addr); end
      checks++; if (rsp_we !== 1'b0) begin errors++; $display("FAIL sr_rsp_we: got %b want 0", rsp_we); end
      cyc(); rvalid_rand = 1'b0; #3;
      checks++; if (pnd_cnt !== 3'd0) begin errors++; $display("FAIL sr_pnd_after: got %0d want 0", pnd_cnt); end
      checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL sr_addr_empty: got %h want 0", rsp_addr); end
      checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL sr_rdata_empty: got %h want 0", bus.rdata_o); end
   endtask

   task automatic test_full();
      cyc(); bus.req_i = 1'b1; bus.addr_i = 32'h0000_1000; bus.we_i = 1'b0; gnt_rand = 1'b1; rvalid_rand = 1'b0; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL full_gnt1: got %b want 1", bus.gnt_o); end
      cyc(); bus.addr_i = 32'h0000_2000; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL full_gnt2: got %b want 1", bus.gnt_o); end
      cyc(); bus.addr_i = 32'h0000_3000; #3;
      checks++; if (pnd_cnt !== 3'd2) begin errors++; $display("FAIL full_pnd: got %0d want 2", pnd_cnt); end
      checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL full_no_gnt: got %b want 0", bus.gnt_o); end
      cyc(); rvalid_rand = 1'b1; #3;
      checks++; if (bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL full_pop: got %b want 1", bus.rvalid_o); end
      checks++; if (rsp_addr !== 32'h0000_1000) begin errors++; $display("FAIL full_head1: got %h want 00001000", rsp_addr); end
      checks++; if (bus.gnt_o !== 1'b0) begin errors++; $display("FAIL full_no_same_cycle_gnt: got %b want 0", bus.gnt_o); end
      cyc(); rvalid_rand = 1'b0; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL full_gnt_after_pop: got %b want 1", bus.gnt_o); end
      checks++; if (rsp_addr !== 32'h0000_2000) begin errors++; $display("FAIL full_head2: got %h want 00002000", rsp_addr); end
      cyc(); bus.req_i = 1'b0; gnt_rand = 1'b0; rvalid_rand = 1'b1; #3;
      checks++; if (pnd_cnt !== 3'd2) begin errors++; $display("FAIL full_pnd2: got %0d want 2", pnd_cnt); end
      checks++; if (rsp_addr !== 32'h0000_2000) begin errors++; $display("FAIL full_drain_a: got %h want 00002000", rsp_addr); end
      cyc(); #3;
      checks++; if (rsp_addr !== 32'h0000_3000) begin errors++; $display("FAIL full_drain_wrap: got %h want 00003000", rsp_addr); end
      cyc(); rvalid_rand = 1'b0; #3;
      checks++; if (pnd_cnt !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", pnd_cnt); end
   endtask

   task automatic test_forced_grant();
      logic exp;
      for (int i = 0; i < 5; i++) begin
         cyc(); bus.req_i = 1'b1; bus.addr_i = 32'h2000_0010; bus.we_i = 1'b1; bus.wdata_i = 32'hCAFE_F00D;
         gnt_rand = 1'b0; rvalid_rand = 1'b0; #3;
         exp = (i == 4);
         checks++; if (bus.gnt_o !== exp) begin errors++; $display("FAIL forced_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp); end
      end
   endtask

   task automatic test_forced_rvalid();
      logic exp;
      for (int k = 0; k < 5; k++) begin
         cyc(); bus.req_i = 1'b0; rvalid_rand = 1'b0; rdata_rand = 32'h1234_5678; #3;
         exp = (k == 4);
         checks++; if (bus.rvalid_o !== exp) begin errors++; $display("FAIL forced_rvalid[%0d]: got %b want %b", k, bus.rvalid_o, exp); end
         if (k == 4) begin
            checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL write_rdata: got %h want 0", bus.rdata_o); end
            checks++; if (rsp_we !== 1'b1) begin errors++; $display("FAIL write_rsp_we: got %b want 1", rsp_we); end
            checks++; if (rsp_addr !== 32'h2000_0010) begin errors++; $display("FAIL write_rsp_addr: got %h want 20000010", rsp_addr); end
         end
      end
      cyc(); #3;
      checks++; if (pnd_cnt !== 3'd0) begin errors++; $display("FAIL forced_rvalid_pnd: got %0d want 0", pnd_cnt); end
   endtask

   task automatic test_back_to_back();
      cyc(); bus.req_i = 1'b1; bus.addr_i = 32'h0000_0100; bus.we_i = 1'b0; gnt_rand = 1'b1; rvalid_rand = 1'b0; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b want 1", bus.gnt_o); end
      cyc(); bus.addr_i = 32'h0000_0104; rvalid_rand = 1'b1; rdata_rand = 32'hAAAA_0001; #3;
      checks++; if (bus.gnt_o !== 1'b1 || bus.rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_pushpop1: got gnt=%b rvalid=%b want 1 1", bus.gnt_o, bus.rvalid_o); end
      checks++; if (rsp_addr !== 32'h0000_0100) begin errors++; $display("FAIL b2b_head1: got %h want 00000100", rsp_addr); end
      checks++; if (bus.rdata_o !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_rdata1: got %h want aaaa0001", bus.rdata_o); end
      cyc(); bus.addr_i = 32'h0000_0108; rdata_rand = 32'hAAAA_0002; #3;
      checks++; if (pnd_cnt !== 3'd1) begin errors++; $display("FAIL b2b_pnd_steady: got %0d want 1", pnd_cnt); end
      checks++; if (rsp_addr !== 32'h0000_0104) begin errors++; $display("FAIL b2b_head2: got %h want 00000104", rsp_addr); end
      cyc(); bus.req_i = 1'b0; rvalid_rand = 1'b0; #3;
      checks++; if (pnd_cnt !== 3'd1 || rsp_addr !== 32'h0000_0108) begin errors++; $display("FAIL b2b_head3: got cnt=%0d addr=%h want 1 00000108", pnd_cnt, rsp_addr); end
      cyc(); bus.req_i = 1'b1; bus.addr_i = 32'h0000_010C; #3;
      checks++; if (bus.gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt_last: got %b want 1", bus.gnt_o); end
      cyc(); bus.req_i = 1'b0; #3;
      checks++; if (pnd_cnt !== 3'd2) begin errors++; $display("FAIL b2b_pnd_before_reset: got %0d want 2", pnd_cnt); end
   endtask

   task automatic test_reset_midflight();
      cyc(); reset = 1'b1; rvalid_rand = 1'b0; #3;
      for (int i = 0; i < 3; i++) begin
         cyc(); reset = 1'b0; rvalid_rand = 1'b1; #3;
         checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_rvalid[%0d]: got %b want 0", i, bus.rvalid_o); end
         checks++; if (pnd_cnt !== 3'd0) begin errors++; $display("FAIL mid_reset_pnd[%0d]: got %0d want 0", i, pnd_cnt); end
      end
      checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_addr: got %h want 0", rsp_addr); end
   endtask

   initial begin
      reset = 1'b1; gnt_rand = 1'b0; rvalid_rand = 1'b0; rdata_rand = '0;
      bus.req_i = 1'b0; bus.addr_i = '0; bus.we_i = 1'b0; bus.be_i = 4'hF; bus.wdata_i = '0;
      test_reset();
      test_single_read();
      test_full();
      test_forced_grant();
      test_forced_rvalid();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
